lsu_ctrl: RTL and testbench

Load/store controller between the execute stage and the 100-byte data memory. It takes one load or store per handshake from execute and forms the effective address. It checks bounds and alignment, drives the memory's write strobe for exactly one cycle, and captures and extends read data. It then returns a tagged response to writeback.

---
 rtl/lsu_ctrl.sv | 157 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller between execute and the byte-addressed data memory.
// Forms the effective address, checks bounds/alignment, strobes writes and returns tagged responses.
module lsu_ctrl #(
   parameter int unsigned MEM_BYTES  = 100,
   parameter bit          ALIGN_WORD = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [15:0] req_base,
   input  logic [15:0] req_offset,
   input  logic [15:0] req_data,
   input  logic [2:0]  req_rd,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_data,
   output logic [2:0]  resp_rd,
   output logic        resp_is_load,
   output logic        resp_fault,
   output logic        busy,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_immd,
   output logic [15:0] mem_wdata,
   output logic [1:0]  mem_memw,
   input  logic [7:0]  mem_byte,
   input  logic [15:0] mem_word
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [2:0]  OP_LB      = 3'b000;
   localparam logic [2:0]  OP_LBU     = 3'b001;
   localparam logic [2:0]  OP_LW      = 3'b010;
   localparam logic [2:0]  OP_SB      = 3'b100;
   localparam logic [2:0]  OP_SW      = 3'b101;
   localparam logic [15:0] BYTE_LIMIT = 16'(MEM_BYTES);
   localparam logic [15:0] WORD_LIMIT = 16'(MEM_BYTES - 2);

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [2:0]  rd_q, rd_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] resp_data_q, resp_data_d;
   logic [2:0]  resp_rd_q, resp_rd_d;
   logic        resp_is_load_q, resp_is_load_d;
   logic        resp_fault_q, resp_fault_d;

   logic        accept;
   logic        is_byte, is_word, is_load, illegal, fault;
   logic [15:0] load_data;

   // Fault decode works purely on the latched request, so it is stable for the whole EXEC cycle.
   always_comb begin
      is_byte = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
      is_word = (op_q == OP_LW) || (op_q == OP_SW);
      is_load = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_LW);
      illegal = !(is_byte || is_word);
      fault   = illegal
             || (is_byte && (addr_q >= BYTE_LIMIT))
             || (is_word && (addr_q > WORD_LIMIT))
             || (is_word && ALIGN_WORD && addr_q[0]);
   end

   always_comb begin
      load_data = 16'h0000;
      if (!fault) begin
         case (op_q)
            OP_LB:   load_data = {{8{mem_byte[7]}}, mem_byte};
            OP_LBU:  load_data = {8'h00, mem_byte};
            OP_LW:   load_data = mem_word;
            default: load_data = 16'h0000;
         endcase
      end
   end

   assign req_ready = rst && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
   assign accept    = req_valid && req_ready;

   // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      rd_d           = rd_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      resp_data_d    = resp_data_q;
      resp_rd_d      = resp_rd_q;
      resp_is_load_d = resp_is_load_q;
      resp_fault_d   = resp_fault_q;
      mem_memw       = 2'b00;

      case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            if (!fault && (op_q == OP_SB)) mem_memw = 2'b01;
            if (!fault && (op_q == OP_SW)) mem_memw = 2'b10;
            resp_data_d    = load_data;
            resp_rd_d      = rd_q;
            resp_is_load_d = is_load;
            resp_fault_d   = fault;
            state_d        = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = accept ? EXEC : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         op_d    = req_op;
         rd_d    = req_rd;
         wdata_d = req_data;
         addr_d  = req_base + req_offset;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         op_q           <= 3'b000;
         rd_q           <= 3'b000;
         addr_q         <= 16'h0000;
         wdata_q        <= 16'h0000;
         resp_data_q    <= 16'h0000;
         resp_rd_q      <= 3'b000;
         resp_is_load_q <= 1'b0;
         resp_fault_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         rd_q           <= rd_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         resp_data_q    <= resp_data_d;
         resp_rd_q      <= resp_rd_d;
         resp_is_load_q <= resp_is_load_d;
         resp_fault_q   <= resp_fault_d;
      end
   end

   assign resp_valid   = (state_q == RESP);
   assign resp_data    = resp_data_q;
   assign resp_rd      = resp_rd_q;
   assign resp_is_load = resp_is_load_q;
   assign resp_fault   = resp_fault_q;
   assign busy         = (state_q != IDLE);
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_immd     = 16'h0000;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a 100-byte behavioural data memory behind it.
module tb_lsu_ctrl;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_BAD = 3'b011;
   localparam logic [2:0] OP_SB  = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [2:0]  req_op, req_rd;
   logic [15:0] req_base, req_offset, req_data;
   logic        resp_valid, resp_ready;
   logic [15:0] resp_data;
   logic [2:0]  resp_rd;
   logic        resp_is_load, resp_fault, busy;
   logic [15:0] mem_addr, mem_immd, mem_wdata;
   logic [1:0]  mem_memw;
   logic [7:0]  mem_byte;
   logic [15:0] mem_word;

   int checks;
   int errors;

   // Results of the most recent run_op transaction.
   int          r_lat, r_memw_cnt;
   logic [1:0]  r_memw_val;
   logic [15:0] r_memw_addr, r_data;
   logic [2:0]  r_rd;
   logic        r_load, r_fault;

   always #5 clk = ~clk;

   lsu_ctrl #(.MEM_BYTES(100), .ALIGN_WORD(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_base(req_base), .req_offset(req_offset), .req_data(req_data), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_is_load(resp_is_load), .resp_fault(resp_fault),
      .busy(busy), .mem_addr(mem_addr), .mem_immd(mem_immd), .mem_wdata(mem_wdata),
      .mem_memw(mem_memw), .mem_byte(mem_byte), .mem_word(mem_word)
   );

   // Memory model; out-of-range reads return junk so faulting loads must zero it themselves.
   logic [7:0] mem [0:99] = '{default: 8'h00};

   always_comb begin
      mem_byte = (mem_addr < 16'd100) ? mem[mem_addr[6:0]] : 8'hA5;
      mem_word = (mem_addr < 16'd99) ? {mem[mem_addr[6:0] + 7'd1], mem[mem_addr[6:0]]} : 16'hA5A5;
   end

   always @(posedge clk) begin
      if (mem_memw == 2'b01 && mem_addr < 16'd100) begin
         mem[mem_addr[6:0]] <= mem_wdata[7:0];
      end else if (mem_memw == 2'b10 && mem_addr < 16'd99) begin
         mem[mem_addr[6:0]]         <= mem_wdata[7:0];
         mem[mem_addr[6:0] + 7'd1]  <= mem_wdata[15:8];
      end
   end

   task automatic set_req(input logic [2:0] op, input logic [15:0] base, input logic [15:0] offset,
                          input logic [15:0] data, input logic [2:0] rd);
      req_op = op; req_base = base; req_offset = offset; req_data = data; req_rd = rd;
   endtask

   // One full transaction with resp_ready held high; records latency, strobes and the response.
   task automatic run_op(input logic [2:0] op, input logic [15:0] base, input logic [15:0] offset,
                         input logic [15:0] data, input logic [2:0] rd);
      int n;
      @(negedge clk);
      set_req(op, base, offset, data, rd);
      req_valid  = 1'b1;
      resp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      r_lat = 0; r_memw_cnt = 0; r_memw_val = 2'b00; r_memw_addr = 16'h0000;
      do begin
         @(negedge clk);
         r_lat++;
         if (mem_memw != 2'b00) begin
            r_memw_cnt++;
            r_memw_val  = mem_memw;
            r_memw_addr = mem_addr;
         end
      end while (!resp_valid && r_lat < 8);
      r_data = resp_data; r_rd = resp_rd; r_load = resp_is_load; r_fault = resp_fault;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      req_valid = 1'b1;
      resp_ready = 1'b1;
      set_req(OP_LW, 16'd0, 16'd0, 16'd0, 3'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_low: got %b want 0", req_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      checks++; if (mem_memw !== 2'b00) begin errors++; $display("FAIL reset_memw: got %b want 00", mem_memw); end
      checks++; if (resp_data !== 16'h0000) begin errors++; $display("FAIL reset_resp_data: got %h want 0000", resp_data); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready_after: got %b want 1", req_ready); end
   endtask

   task automatic test_sw_lw;
      run_op(OP_SW, 16'd10, 16'd4, 16'hBEEF, 3'd3);
      checks++; if (r_lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", r_lat); end
      checks++; if (r_memw_cnt !== 1) begin errors++; $display("FAIL sw_strobe_count: got %0d want 1", r_memw_cnt); end
      checks++; if (r_memw_val !== 2'b10) begin errors++; $display("FAIL sw_strobe_kind: got %b want 10", r_memw_val); end
      checks++; if (r_memw_addr !== 16'd14) begin errors++; $display("FAIL sw_addr: got %0d want 14", r_memw_addr); end
      checks++; if (r_fault !== 1'b0 || r_load !== 1'b0 || r_data !== 16'h0000) begin
         errors++; $display("FAIL sw_resp: got fault=%b load=%b data=%h want 0 0 0000", r_fault, r_load, r_data); end
      run_op(OP_LW, 16'd14, 16'd0, 16'h0000, 3'd5);
      checks++; if (r_data !== 16'hBEEF) begin errors++; $display("FAIL lw_data: got %h want beef", r_data); end
      checks++; if (r_load !== 1'b1 || r_fault !== 1'b0) begin
         errors++; $display("FAIL lw_flags: got load=%b fault=%b want 1 0", r_load, r_fault); end
      checks++; if (r_rd !== 3'd5) begin errors++; $display("FAIL lw_rd: got %0d want 5", r_rd); end
      checks++; if (r_memw_cnt !== 0) begin errors++; $display("FAIL lw_no_strobe: got %0d want 0", r_memw_cnt); end
   endtask

   task automatic test_byte_ext;
      run_op(OP_SB, 16'd20, 16'd0, 16'h1280, 3'd1);
      checks++; if (r_memw_cnt !== 1 || r_memw_val !== 2'b01) begin
         errors++; $display("FAIL sb_strobe: got cnt=%0d kind=%b want 1 01", r_memw_cnt, r_memw_val); end
      run_op(OP_LB, 16'd20, 16'd0, 16'h0000, 3'd2);
      checks++; if (r_data !== 16'hFF80) begin errors++; $display("FAIL lb_sign_ext: got %h want ff80", r_data); end
      run_op(OP_LBU, 16'd20, 16'd0, 16'h0000, 3'd2);
      checks++; if (r_data !== 16'h0080) begin errors++; $display("FAIL lbu_zero_ext: got %h want 0080", r_data); end
   endtask

   task automatic test_faults;
      run_op(OP_LB, 16'd100, 16'd0, 16'h0000, 3'd1);
      checks++; if (r_fault !== 1'b1 || r_data !== 16'h0000) begin
         errors++; $display("FAIL lb_oob: got fault=%b data=%h want 1 0000", r_fault, r_data); end
      run_op(OP_LB, 16'd99, 16'd0, 16'h0000, 3'd1);
      checks++; if (r_fault !== 1'b0) begin errors++; $display("FAIL lb_last_byte: got fault=%b want 0", r_fault); end
      run_op(OP_SW, 16'd99, 16'd0, 16'h7777, 3'd1);
      checks++; if (r_fault !== 1'b1 || r_memw_cnt !== 0) begin
         errors++; $display("FAIL sw_oob: got fault=%b strobes=%0d want 1 0", r_fault, r_memw_cnt); end
      run_op(OP_SW, 16'd7, 16'd0, 16'h7777, 3'd1);
      checks++; if (r_fault !== 1'b1 || r_memw_cnt !== 0) begin
         errors++; $display("FAIL sw_misaligned: got fault=%b strobes=%0d want 1 0", r_fault, r_memw_cnt); end
      run_op(OP_BAD, 16'd4, 16'd0, 16'h7777, 3'd1);
      checks++; if (r_fault !== 1'b1 || r_load !== 1'b0 || r_memw_cnt !== 0) begin
         errors++; $display("FAIL illegal_op: got fault=%b load=%b strobes=%0d want 1 0 0", r_fault, r_load, r_memw_cnt); end
      run_op(OP_SW, 16'd98, 16'd0, 16'h1234, 3'd1);
      checks++; if (r_fault !== 1'b0 || r_memw_cnt !== 1) begin
         errors++; $display("FAIL sw_last_word: got fault=%b strobes=%0d want 0 1", r_fault, r_memw_cnt); end
      run_op(OP_LW, 16'd98, 16'd0, 16'h0000, 3'd1);
      checks++; if (r_data !== 16'h1234) begin errors++; $display("FAIL lw_last_word: got %h want 1234", r_data); end
   endtask

   task automatic test_wrap;
      run_op(OP_SB, 16'hFFFF, 16'h0003, 16'h00C3, 3'd0);
      checks++; if (r_memw_addr !== 16'd2 || r_fault !== 1'b0 || r_memw_cnt !== 1) begin
         errors++; $display("FAIL wrap_addr: got addr=%0d fault=%b strobes=%0d want 2 0 1", r_memw_addr, r_fault, r_memw_cnt); end
   endtask

   task automatic test_back_to_back;
      int k, n_resp;
      int t_resp[4];
      logic [15:0] d_resp[4];
      logic [2:0] rd_resp[4];
      logic acc;
      // Stall writeback on an LBU at the wrapped address while the next request waits.
      @(negedge clk);
      set_req(OP_LBU, 16'hFFFF, 16'h0003, 16'h0000, 3'd6);
      req_valid  = 1'b1;
      resp_ready = 1'b0;
      @(posedge clk);
      #1 set_req(OP_LW, 16'd10, 16'd4, 16'h0000, 3'd1);
      repeat (2) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         checks++; if (resp_valid !== 1'b1 || resp_data !== 16'h00C3 || resp_rd !== 3'd6) begin
            errors++; $display("FAIL stall_hold c%0d: got v=%b data=%h rd=%0d want 1 00c3 6", c, resp_valid, resp_data, resp_rd); end
         checks++; if (req_ready !== 1'b0 || mem_memw !== 2'b00) begin
            errors++; $display("FAIL stall_block c%0d: got ready=%b memw=%b want 0 00", c, req_ready, mem_memw); end
      end
      resp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", req_ready); end
      @(posedge clk);
      #1 set_req(OP_LBU, 16'd20, 16'd0, 16'h0000, 3'd2);
      k = 1;
      n_resp = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (resp_valid && n_resp < 4) begin
            t_resp[n_resp] = c; d_resp[n_resp] = resp_data; rd_resp[n_resp] = resp_rd;
            n_resp++;
         end
         acc = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            k++;
            if (k == 2) set_req(OP_LB, 16'd0, 16'd20, 16'h0000, 3'd4);
            else req_valid = 1'b0;
         end
      end
      checks++; if (n_resp !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n_resp); end
      if (n_resp == 3) begin
         checks++; if (t_resp[0] !== 1 || t_resp[1] !== 3 || t_resp[2] !== 5) begin
            errors++; $display("FAIL b2b_spacing: got %0d %0d %0d want 1 3 5", t_resp[0], t_resp[1], t_resp[2]); end
         checks++; if (d_resp[0] !== 16'hBEEF || d_resp[1] !== 16'h0080 || d_resp[2] !== 16'hFF80) begin
            errors++; $display("FAIL b2b_data: got %h %h %h want beef 0080 ff80", d_resp[0], d_resp[1], d_resp[2]); end
         checks++; if (rd_resp[0] !== 3'd1 || rd_resp[1] !== 3'd2 || rd_resp[2] !== 3'd4) begin
            errors++; $display("FAIL b2b_rd: got %0d %0d %0d want 1 2 4", rd_resp[0], rd_resp[1], rd_resp[2]); end
      end
   endtask

   task automatic test_reset_mid_exec;
      @(negedge clk);
      set_req(OP_SB, 16'd30, 16'd0, 16'h0055, 3'd7);
      req_valid  = 1'b1;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #1;
      checks++; if (mem_memw !== 2'b01) begin errors++; $display("FAIL exec_strobe_armed: got %b want 01", mem_memw); end
      rst = 1'b0;
      #1;
      checks++; if (mem_memw !== 2'b00 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_drops_store: got memw=%b busy=%b want 00 0", mem_memw, busy); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_op(OP_LBU, 16'd30, 16'd0, 16'h0000, 3'd7);
      checks++; if (r_data !== 16'h0000) begin errors++; $display("FAIL dropped_store_readback: got %h want 0000", r_data); end
   endtask

   task automatic test_reset_in_resp;
      @(negedge clk);
      set_req(OP_LW, 16'd14, 16'd0, 16'h0000, 3'd3);
      req_valid  = 1'b1;
      resp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_data !== 16'hBEEF) begin
         errors++; $display("FAIL resp_before_reset: got v=%b data=%h want 1 beef", resp_valid, resp_data); end
      rst = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || resp_data !== 16'h0000 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_discards_resp: got v=%b data=%h busy=%b want 0 0000 0", resp_valid, resp_data, busy); end
      @(negedge clk);
      rst = 1'b1;
      resp_ready = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_sw_lw();
      test_byte_ext();
      test_faults();
      test_wrap();
      test_back_to_back();
      test_reset_mid_exec();
      test_reset_in_resp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
